// File: rtl/cu_counter_pkg.sv
// cu_counter_pkg: shared constants for the control-unit state counter.
// Holds the control-state numbers and the opcode encodings.
package cu_counter_pkg;

  localparam int FETCH1 = 0;
  localparam int AND1   = 3;
  localparam int ADD1   = 5;
  localparam int JMP1   = 7;
  localparam int INC1   = 8;

  localparam int OP_AND = 0;
  localparam int OP_ADD = 1;
  localparam int OP_JMP = 2;
  localparam int OP_INC = 3;

endpackage

// File: rtl/cu_counter_decode.sv
// cu_counter_decode: combinational opcode -> execute start state.
// Ports: opcode (in, opcode_bits), start (out, N); unmapped opcodes -> FETCH1.
module cu_counter_decode
  import cu_counter_pkg::*;
#(
  parameter int opcode_bits = 2,
  parameter int N           = 4
) (
  input  logic [opcode_bits-1:0] opcode,
  output logic [N-1:0]           start
);

  always_comb begin
    start = N'(FETCH1);
    unique case (1'b1)
      (opcode == opcode_bits'(OP_AND)): start = N'(AND1);
      (opcode == opcode_bits'(OP_ADD)): start = N'(ADD1);
      (opcode == opcode_bits'(OP_JMP)): start = N'(JMP1);
      (opcode == opcode_bits'(OP_INC)): start = N'(INC1);
      default:                          start = N'(FETCH1);
    endcase
  end

endmodule

// File: rtl/cu_counter.sv
// cu_counter: microsequencer state counter for the CPU control unit.
// Ports: clk, rst (sync, active-high), clr, load, inc, opcode -> q (N, registered).
// Build macro CU_COUNTER_SAT_EN: increment saturates at all-ones instead of wrapping.
module cu_counter
  import cu_counter_pkg::*;
#(
  parameter int opcode_bits = 2,
  parameter int N           = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   load,
  input  logic                   inc,
  input  logic [opcode_bits-1:0] opcode,
  output logic [N-1:0]           q
);

  logic [N-1:0] start;
  logic [N-1:0] q_inc;

  cu_counter_decode #(
    .opcode_bits(opcode_bits),
    .N          (N)
  ) u_decode (
    .opcode(opcode),
    .start (start)
  );

`ifdef CU_COUNTER_SAT_EN
  assign q_inc = (&q) ? q : q + N'(1);
`else
  assign q_inc = q + N'(1);
`endif

  // load together with inc is a conflict: neither acts, q holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= N'(FETCH1);
    end else if (clr) begin
      q <= N'(FETCH1);
    end else if (load && inc) begin
      q <= q;
    end else if (load) begin
      q <= start;
    end else if (inc) begin
      q <= q_inc;
    end
  end

endmodule

// File: tb/tb_cu_counter.sv
// tb_cu_counter: directed plus randomized check of cu_counter
// against an arithmetic reference model.
module tb_cu_counter;

  localparam int OB = 2;
  localparam int N  = 4;
  localparam int MAXQ = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic          inc = 1'b0;
  logic [OB-1:0] opcode = '0;
  logic [N-1:0]  q;

  int passed = 0;
  int total  = 0;
  int exp_q  = 0;
  bit valid  = 1'b0;
  int start_tbl [4] = '{3, 5, 7, 8};

  cu_counter #(.opcode_bits(OB), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .opcode(opcode),
    .q     (q)
  );

  always #5 clk = ~clk;

  // Reference model: next state straight from the priority rules.
  always @(posedge clk) begin
    if (rst || clr) begin
      exp_q = 0;
    end else if (load && inc) begin
      exp_q = exp_q;
    end else if (load) begin
      exp_q = start_tbl[int'(opcode)];
    end else if (inc) begin
`ifdef CU_COUNTER_SAT_EN
      exp_q = (exp_q + 1 > MAXQ) ? MAXQ : exp_q + 1;
`else
      exp_q = (exp_q + 1) % (MAXQ + 1);
`endif
    end
    if (rst) valid = 1'b1;
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (valid) begin
      total++;
      if (q !== N'(exp_q))
        $display("FAIL model_cmp t=%0t q=%0d expected=%0d", $time, q, exp_q);
      else
        passed++;
    end
  end

  task automatic step(input logic r, input logic c, input logic l,
                      input logic i, input logic [OB-1:0] op);
    @(negedge clk);
    #1;
    rst = r; clr = c; load = l; inc = i; opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int want);
    total++;
    if (q !== N'(want))
      $display("FAIL %s q=%0d expected=%0d", name, q, want);
    else
      passed++;
  endtask

  initial begin
    step(1, 0, 0, 0, 0); lit("reset", 0);
    step(0, 1, 0, 0, 0); lit("clr_idle", 0);
    step(0, 0, 0, 0, 0); lit("hold0", 0);
    step(0, 0, 1, 0, 2'b00); lit("load_and", 3);
    step(0, 0, 1, 0, 2'b01); lit("load_add", 5);
    step(0, 0, 1, 0, 2'b10); lit("load_jmp", 7);
    step(0, 0, 1, 0, 2'b11); lit("load_inc", 8);
    step(0, 0, 0, 1, 0); lit("inc9", 9);
    step(0, 0, 0, 1, 0); lit("inc10", 10);
    step(0, 0, 1, 1, 2'b01); lit("conflict", 10);
    step(0, 1, 0, 0, 0); lit("clr", 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11); lit("clr_prio", 0);
    step(0, 0, 1, 0, 2'b11); lit("reload8", 8);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 0);
    lit("at_max", 15);
    step(0, 0, 0, 1, 0);
`ifdef CU_COUNTER_SAT_EN
    lit("sat", 15);
`else
    lit("wrap", 0);
`endif
    step(0, 0, 1, 0, 2'b10); lit("load_jmp2", 7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11); lit("rst_prio", 0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0),
           OB'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
